pipe_regs_fde: RTL and testbench
================================

// Module: pipe_regs_fde
// PURPOSE
//  Fetch/decode/execute pipeline register bank; the responder to the hazard unit's StallF/StallD/FlushD/FlushE requests.
//  Holds the PC register, the IF/ID register and the ID/EX register, and inserts bubbles on flush.
//  Drives Rs1D/Rs2D/Rs1E/Rs2E/RdE back to the hazard unit, closing the loop.
//  Keeps saturating stall/flush cycle counters for performance debug.
// PARAMETERS
//  XLEN      32            datapath width
//  CTRLW     12            width of decoded control bundle (RegWrite, ResultSrc, MemWrite, ...)
//  RESET_PC  32'h0000_0000 PCF value after reset
//  CNTW      16            width of each performance counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-low
//  StallF     in   1      hold PCF
//  StallD     in   1      hold IF/ID register
//  FlushD     in   1      bubble IF/ID register
//  FlushE     in   1      bubble ID/EX register
//  PCSrcE     in   1      redirect fetch to PCTargetE
//  PCTargetE  in   XLEN   branch/jump target
//  InstrF     in   32     instruction read at PCF (combinational imem)
//  RD1D,RD2D  in   XLEN   register-file read data
//  ImmExtD    in   XLEN   extended immediate
//  CtrlD      in   CTRLW  decoded control; all-zero = no architectural effect
//  PCF        out  XLEN   fetch PC
//  InstrD,PCD,PCPlus4D  out 32/XLEN/XLEN  IF/ID contents
//  Rs1D,Rs2D  out  5      InstrD[19:15], InstrD[24:20] (combinational)
//  ValidD     out  1      IF/ID holds a real instruction
//  PCE,PCPlus4E,RD1E,RD2E,ImmExtE  out XLEN  ID/EX datapath
//  Rs1E,Rs2E,RdE  out 5   ID/EX register addresses
//  CtrlE      out  CTRLW  ID/EX control bundle
//  ValidE     out  1      ID/EX holds a real instruction
//  StallCnt,FlushCnt  out CNTW  performance counters
// BEHAVIOUR
//  Reset (rst=0, async): PCF=RESET_PC; every IF/ID and ID/EX field=0; ValidD=ValidE=0; counters=0.
//  Zeroed InstrD gives Rs1D=Rs2D=0, so it never raises a false load stall.
//  PC register, priority order:
//    PCSrcE=1 -> PCF<=PCTargetE. Redirect wins over StallF and is never lost.
//    else StallF=1 -> hold.
//    else PCF<=PCF+4 (mod 2^XLEN, wraps silently).
//  IF/ID register, priority order:
//    FlushD=1 -> all fields 0, ValidD<=0.
//    else StallD=1 -> hold, including ValidD.
//    else InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1.
//  ID/EX register, priority order:
//    FlushE=1 -> all fields and CtrlE=0, ValidE<=0.
//    else capture D-stage values and RdE=InstrD[11:7]; ValidE<=ValidD.
//    No ID/EX stall exists. StallD with FlushE=0 is legal and re-issues the same instruction to E.
//  Latency: one cycle per stage. Instruction fetched at PCF in cycle n is in D at n+1 and in E at n+2 if unstalled.
//  Load-use (StallF=StallD=FlushE=1): F and D hold, E gets one bubble. Sequence resumes unchanged next cycle.
//  Taken branch (FlushD=FlushE=PCSrcE=1): both younger instructions squashed. Target in D two cycles later.
//  StallD and FlushD together: flush wins.
//  StallCnt += 1 each cycle StallD=1; FlushCnt += 1 each cycle FlushE=1. Both saturate at all-ones, no wrap.
//  Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.
// TESTING
//  Reset release, no hazards, InstrF=PC-indexed ROM -> PCF 0,4,8,...; InstrD=ROM[PCF-4] next cycle; ValidD=1 from cycle 1, ValidE=1 from cycle 2.
//  StallF=StallD=FlushE=1 for 1 cycle at PCF=0x10 -> PCF and InstrD hold; ID/EX zero with ValidE=0; InstrD reaches E next cycle; StallCnt=1.
//  PCSrcE=FlushD=FlushE=1, PCTargetE=0x100 -> next cycle PCF=0x100, ID/EX and IF/ID zero; InstrD=ROM[0x100] one cycle later; FlushCnt=1.
//  PCSrcE=1 and StallF=1 in the same cycle -> PCF=PCTargetE; FlushD=1 and StallD=1 together -> ValidD=0.
//  PCF=0xFFFF_FFFC, no hazard -> PCF wraps to 0; hold StallD for 2^CNTW+5 cycles -> StallCnt stays 0xFFFF.
//  Assert rst=0 between clock edges mid-stream -> outputs reach reset values before the next edge; restart fetches RESET_PC.

Source files
------------

// File: rtl/pipe_regs_fde.sv
// Fetch/decode/execute pipeline register bank: PC, IF/ID and ID/EX registers driven by
// hazard-unit stall/flush requests, plus saturating stall/flush performance counters.
module pipe_regs_fde #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          CTRLW    = 12,
    parameter logic [XLEN-1:0]      RESET_PC = '0,
    parameter int unsigned          CNTW     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic [31:0]      InstrF,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [CTRLW-1:0] CtrlD,
    output logic [XLEN-1:0]  PCF,
    output logic [31:0]      InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic [4:0]       Rs1D,
    output logic [4:0]       Rs2D,
    output logic             ValidD,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [CTRLW-1:0] CtrlE,
    output logic             ValidE,
    output logic [CNTW-1:0]  StallCnt,
    output logic [CNTW-1:0]  FlushCnt
);

    logic [XLEN-1:0] pcPlus4F;
    logic [XLEN-1:0] pcNext;

    assign pcPlus4F = PCF + XLEN'(4);

    // Source operand addresses feed the hazard unit directly; a zeroed InstrD yields x0/x0.
    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];

    // Redirect outranks a fetch stall so a taken branch is never lost.
    always_comb begin
        pcNext = pcPlus4F;
        if (PCSrcE) begin
            pcNext = PCTargetE;
        end else if (StallF) begin
            pcNext = PCF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PCF <= RESET_PC;
        end else begin
            PCF <= pcNext;
        end
    end

    // IF/ID register: flush beats stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= pcPlus4F;
            ValidD   <= 1'b1;
        end
    end

    // ID/EX register: no stall path, so a held D stage re-issues unless E is flushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PCE      <= '0;
            PCPlus4E <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            CtrlE    <= '0;
            ValidE   <= 1'b0;
        end else if (FlushE) begin
            PCE      <= '0;
            PCPlus4E <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            CtrlE    <= '0;
            ValidE   <= 1'b0;
        end else begin
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= InstrD[11:7];
            CtrlE    <= CtrlD;
            ValidE   <= ValidD;
        end
    end

    // Saturating performance counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && (StallCnt != '1)) begin
                StallCnt <= StallCnt + CNTW'(1);
            end
            if (FlushE && (FlushCnt != '1)) begin
                FlushCnt <= FlushCnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_regs_fde.sv
// Randomised and directed bench for pipe_regs_fde against a per-cycle behavioural model.
module tb_pipe_regs_fde;

    localparam int VW = 359;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, FlushE = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] InstrF;
    logic [31:0] RD1D = '0, RD2D = '0, ImmExtD = '0;
    logic [11:0] CtrlD = '0;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic        ValidD, ValidE;
    logic [31:0] PCE, PCPlus4E, RD1E, RD2E, ImmExtE;
    logic [11:0] CtrlE;
    logic [15:0] StallCnt, FlushCnt;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [31:0] mPCF, mInstrD, mPCD, mPCPlus4D, mPCE, mPCPlus4E, mRD1E, mRD2E, mImmE;
    logic [4:0]  mRs1E, mRs2E, mRdE;
    logic [11:0] mCtrlE;
    logic        mValidD, mValidE;
    int          mStall, mFlush;

    always #5 clk = ~clk;

    function automatic logic [31:0] romWord(input logic [31:0] a);
        return (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
    endfunction

    assign InstrF = romWord(PCF);

    pipe_regs_fde dut (
        .clk(clk), .rst(rst),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .CtrlD(CtrlD),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .ValidD(ValidD),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .CtrlE(CtrlE), .ValidE(ValidE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    function automatic logic [VW-1:0] dutVec();
        return {PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, ValidD,
                PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, CtrlE, ValidE,
                StallCnt, FlushCnt};
    endfunction

    function automatic logic [VW-1:0] modelVec();
        return {mPCF, mInstrD, mPCD, mPCPlus4D, mInstrD[19:15], mInstrD[24:20], mValidD,
                mPCE, mPCPlus4E, mRD1E, mRD2E, mImmE, mRs1E, mRs2E, mRdE, mCtrlE, mValidE,
                16'(mStall), 16'(mFlush)};
    endfunction

    task automatic modelReset();
        mPCF = '0; mInstrD = '0; mPCD = '0; mPCPlus4D = '0; mValidD = 1'b0;
        mPCE = '0; mPCPlus4E = '0; mRD1E = '0; mRD2E = '0; mImmE = '0;
        mRs1E = '0; mRs2E = '0; mRdE = '0; mCtrlE = '0; mValidE = 1'b0;
        mStall = 0; mFlush = 0;
    endtask

    task automatic clearHazards();
        StallF = 0; StallD = 0; FlushD = 0; FlushE = 0; PCSrcE = 0; PCTargetE = '0;
    endtask

    task automatic setData();
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; CtrlD = 12'($urandom);
    endtask

    // One clock: model computes next state from current inputs, DUT is sampled #1 after the edge.
    task automatic step();
        logic [31:0] nPCF, nInstrD, nPCD, nPCP4D, nPCE, nPCP4E, nRD1, nRD2, nImm;
        logic [4:0]  nRs1, nRs2, nRd;
        logic [11:0] nCtrl;
        logic        nVD, nVE;
        nPCF = PCSrcE ? PCTargetE : (StallF ? mPCF : mPCF + 32'd4);
        if (FlushD) begin
            nInstrD = '0; nPCD = '0; nPCP4D = '0; nVD = 1'b0;
        end else if (StallD) begin
            nInstrD = mInstrD; nPCD = mPCD; nPCP4D = mPCPlus4D; nVD = mValidD;
        end else begin
            nInstrD = romWord(mPCF); nPCD = mPCF; nPCP4D = mPCF + 32'd4; nVD = 1'b1;
        end
        if (FlushE) begin
            nPCE = '0; nPCP4E = '0; nRD1 = '0; nRD2 = '0; nImm = '0;
            nRs1 = '0; nRs2 = '0; nRd = '0; nCtrl = '0; nVE = 1'b0;
        end else begin
            nPCE = mPCD; nPCP4E = mPCPlus4D; nRD1 = RD1D; nRD2 = RD2D; nImm = ImmExtD;
            nRs1 = mInstrD[19:15]; nRs2 = mInstrD[24:20]; nRd = mInstrD[11:7];
            nCtrl = CtrlD; nVE = mValidD;
        end
        @(posedge clk);
        #1;
        mPCF = nPCF; mInstrD = nInstrD; mPCD = nPCD; mPCPlus4D = nPCP4D; mValidD = nVD;
        mPCE = nPCE; mPCPlus4E = nPCP4E; mRD1E = nRD1; mRD2E = nRD2; mImmE = nImm;
        mRs1E = nRs1; mRs2E = nRs2; mRdE = nRd; mCtrlE = nCtrl; mValidE = nVE;
        if (StallD && mStall < 65535) mStall++;
        if (FlushE && mFlush < 65535) mFlush++;
    endtask

    task automatic doReset();
        rst = 1'b0;
        clearHazards();
        setData();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        doReset();
        tests++;
        if (PCF !== 32'h0 || ValidD !== 1'b0 || ValidE !== 1'b0 || InstrD !== '0) begin
            fails++;
            $display("FAIL reset_basic: PCF=%h ValidD=%b ValidE=%b InstrD=%h, want 0/0/0/0",
                     PCF, ValidD, ValidE, InstrD);
        end
        tests++;
        if (dutVec() !== modelVec()) begin
            fails++;
            $display("FAIL reset_vec: got %h want %h", dutVec(), modelVec());
        end
    endtask

    task automatic test_sequential();
        doReset();
        for (int k = 1; k <= 8; k++) begin
            setData();
            step();
            tests++;
            if (PCF !== 32'(4 * k) || InstrD !== romWord(32'(4 * (k - 1))) || ValidD !== 1'b1) begin
                fails++;
                $display("FAIL seq_fetch k=%0d: PCF=%h InstrD=%h ValidD=%b, want %h %h 1",
                         k, PCF, InstrD, ValidD, 32'(4 * k), romWord(32'(4 * (k - 1))));
            end
            tests++;
            if (ValidE !== (k >= 2)) begin
                fails++;
                $display("FAIL seq_validE k=%0d: got %b want %b", k, ValidE, k >= 2);
            end
            tests++;
            if (dutVec() !== modelVec()) begin
                fails++;
                $display("FAIL seq_vec k=%0d: got %h want %h", k, dutVec(), modelVec());
            end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] heldInstr;
        doReset();
        for (int k = 0; k < 4; k++) begin setData(); step(); end
        heldInstr = romWord(32'hC);
        StallF = 1; StallD = 1; FlushE = 1;
        step();
        tests++;
        if (PCF !== 32'h10 || InstrD !== heldInstr || ValidE !== 1'b0 || CtrlE !== '0
            || PCE !== '0 || StallCnt !== 16'd1) begin
            fails++;
            $display("FAIL load_use_hold: PCF=%h InstrD=%h ValidE=%b CtrlE=%h PCE=%h StallCnt=%0d, want 10 %h 0 0 0 1",
                     PCF, InstrD, ValidE, CtrlE, PCE, StallCnt, heldInstr);
        end
        clearHazards();
        step();
        tests++;
        if (PCF !== 32'h14 || RdE !== heldInstr[11:7] || Rs1E !== heldInstr[19:15]
            || PCE !== 32'hC || ValidE !== 1'b1) begin
            fails++;
            $display("FAIL load_use_resume: PCF=%h RdE=%0d Rs1E=%0d PCE=%h ValidE=%b, want 14 %0d %0d c 1",
                     PCF, RdE, Rs1E, PCE, ValidE, heldInstr[11:7], heldInstr[19:15]);
        end
    endtask

    task automatic test_branch();
        doReset();
        for (int k = 0; k < 5; k++) begin setData(); step(); end
        PCSrcE = 1; FlushD = 1; FlushE = 1; PCTargetE = 32'h100;
        step();
        tests++;
        if (PCF !== 32'h100 || ValidD !== 1'b0 || InstrD !== '0 || PCD !== '0
            || ValidE !== 1'b0 || RD1E !== '0 || FlushCnt !== 16'd1) begin
            fails++;
            $display("FAIL branch_squash: PCF=%h ValidD=%b InstrD=%h ValidE=%b RD1E=%h FlushCnt=%0d, want 100 0 0 0 0 1",
                     PCF, ValidD, InstrD, ValidE, RD1E, FlushCnt);
        end
        clearHazards();
        step();
        tests++;
        if (InstrD !== romWord(32'h100) || PCD !== 32'h100 || PCF !== 32'h104) begin
            fails++;
            $display("FAIL branch_target: InstrD=%h PCD=%h PCF=%h, want %h 100 104",
                     InstrD, PCD, PCF, romWord(32'h100));
        end
    endtask

    task automatic test_priority();
        logic [31:0] tgt;
        tgt = {$urandom_range(1, 32'h3FFF_FFFF), 2'b00};
        PCSrcE = 1; StallF = 1; PCTargetE = tgt;
        step();
        tests++;
        if (PCF !== tgt) begin
            fails++;
            $display("FAIL redirect_over_stall: PCF=%h want %h", PCF, tgt);
        end
        clearHazards();
        step();
        StallD = 1; FlushD = 1;
        step();
        tests++;
        if (ValidD !== 1'b0 || InstrD !== '0) begin
            fails++;
            $display("FAIL flush_over_stall: ValidD=%b InstrD=%h want 0 0", ValidD, InstrD);
        end
        clearHazards();
    endtask

    task automatic test_wrap();
        PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
        step();
        clearHazards();
        step();
        tests++;
        if (PCF !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin
            fails++;
            $display("FAIL pc_wrap: PCF=%h PCD=%h PCPlus4D=%h want 0 fffffffc 0", PCF, PCD, PCPlus4D);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 400; c++) begin
            StallF = ($urandom_range(0, 7) == 0);
            StallD = ($urandom_range(0, 7) == 0);
            FlushD = ($urandom_range(0, 9) == 0);
            FlushE = ($urandom_range(0, 7) == 0);
            PCSrcE = ($urandom_range(0, 9) == 0);
            PCTargetE = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            setData();
            step();
            tests++;
            if (dutVec() !== modelVec()) begin
                fails++;
                $display("FAIL random_vec c=%0d: got %h want %h", c, dutVec(), modelVec());
            end
        end
        clearHazards();
    endtask

    task automatic test_saturate();
        doReset();
        StallD = 1;
        for (int c = 0; c < 65536 + 5; c++) step();
        tests++;
        if (StallCnt !== 16'hFFFF || FlushCnt !== 16'h0) begin
            fails++;
            $display("FAIL stall_saturate: StallCnt=%h FlushCnt=%h want ffff 0", StallCnt, FlushCnt);
        end
        clearHazards();
    endtask

    task automatic test_async_reset();
        doReset();
        for (int k = 0; k < 6; k++) begin
            FlushE = (k == 3); StallD = (k == 4);
            setData();
            step();
        end
        clearHazards();
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        tests++;
        if (dutVec() !== modelVec()) begin
            fails++;
            $display("FAIL async_reset: got %h want %h", dutVec(), modelVec());
        end
        #2;
        rst = 1'b1;
        step();
        tests++;
        if (PCF !== 32'h4 || InstrD !== romWord(32'h0) || ValidD !== 1'b1) begin
            fails++;
            $display("FAIL async_restart: PCF=%h InstrD=%h ValidD=%b want 4 %h 1",
                     PCF, InstrD, ValidD, romWord(32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_load_use();
        test_branch();
        test_priority();
        test_wrap();
        test_random();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
